// File: rtl/cpu_defs.sv
// Shared CPU definitions: operand widths, the multicycle op encoding and
// small decode helpers used by the multicycle sequencer.
//   uint32_t / uint64_t   - architectural register and {HI,LO} widths
//   oper_t                - multicycle op selector presented with a request
//   mc_state_t            - sequencer FSM states
//   MULTICYC_MUL_LATENCY  - default accept-to-result latency of multiply ops
package cpu_defs;

    typedef logic [31:0] uint32_t;
    typedef logic [63:0] uint64_t;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MADD  = 4'd4,
        MADDU = 4'd5,
        MSUB  = 4'd6,
        MSUBU = 4'd7,
        MUL   = 4'd8
    } oper_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL_WAIT,
        DIV_RUN,
        DIV_FIX,
        DONE
    } mc_state_t;

    localparam int MULTICYC_MUL_LATENCY = 2;

    function automatic logic op_is_div(oper_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    // Signed ops sign-extend their operands; MUL writes a GPR and is signed.
    function automatic logic op_is_signed(oper_t op);
        return (op == MULT) || (op == DIV) || (op == MADD) ||
               (op == MSUB) || (op == MUL);
    endfunction

endpackage

// File: rtl/multicyc_seq_if.sv
// Request/result bundle between the pipeline and the multicycle sequencer.
//   req_*      - op, operands and current {HI,LO}, with valid/ready handshake
//   result_*   - {HI,LO} and GPR results with valid/ready handshake
//   hilo_we    - result_hilo should be written to {HI,LO}
//   reg_we     - result_reg should be written to the destination GPR
// master: the pipeline side; slave: the sequencer.
interface multicyc_seq_if;
    import cpu_defs::*;

    logic    req_valid;
    oper_t   req_op;
    uint32_t req_a;
    uint32_t req_b;
    uint64_t hilo_in;
    logic    req_ready;

    logic    result_valid;
    logic    result_ready;
    uint64_t result_hilo;
    uint32_t result_reg;
    logic    hilo_we;
    logic    reg_we;

    modport master (
        output req_valid, req_op, req_a, req_b, hilo_in, result_ready,
        input  req_ready, result_valid, result_hilo, result_reg, hilo_we, reg_we
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, hilo_in, result_ready,
        output req_ready, result_valid, result_hilo, result_reg, hilo_we, reg_we
    );

endinterface

// File: rtl/multicyc_seq_div.sv
// div_iter: iterative restoring divider, one quotient bit per clock.
//   clk, rst     - clock, synchronous active-high reset
//   start        - load a/b and begin ITERS iterations
//   is_signed    - treat a/b as two's complement
//   a, b         - dividend, divisor
//   done         - iterations finished; quotient/remainder are valid
//   quotient     - sign-corrected quotient
//   remainder    - sign-corrected remainder (takes the sign of the dividend)
// Divide by zero falls out of the algorithm: every step subtracts zero, so the
// magnitude quotient is all ones and the remainder is |a|.
module div_iter
    import cpu_defs::*;
#(
    parameter int ITERS = 32
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  logic    is_signed,
    input  uint32_t a,
    input  uint32_t b,
    output logic    done,
    output uint32_t quotient,
    output uint32_t remainder
);

    localparam int CW = $clog2(ITERS + 1);

    logic [CW-1:0] cnt;
    logic          running;

    uint32_t rem_q;      // partial remainder
    uint32_t quot_q;     // dividend bits shift out the top, quotient bits in
    uint32_t divisor_q;
    logic    neg_quot;
    logic    neg_rem;

    logic [32:0] partial;
    logic        fits;

    // NOTE: every combinational output gets a value on every path, so no latch.
    always_comb begin
        partial = {rem_q, quot_q[31]};
        fits    = (partial >= {1'b0, divisor_q});
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CW'(ITERS);
        end else if (running && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // NOTE: datapath registers are not reset; control (running/cnt) decides
    // when their contents mean anything.
    always_ff @(posedge clk) begin
        if (start) begin
            rem_q     <= '0;
            quot_q    <= (is_signed && a[31]) ? -a : a;
            divisor_q <= (is_signed && b[31]) ? -b : b;
            neg_quot  <= is_signed && (a[31] ^ b[31]);
            neg_rem   <= is_signed && a[31];
        end else if (running && (cnt != '0)) begin
            rem_q  <= fits ? 32'(partial - {1'b0, divisor_q}) : partial[31:0];
            quot_q <= {quot_q[30:0], fits};
        end
    end

    assign done      = running && (cnt == '0);
    assign quotient  = neg_quot ? -quot_q : quot_q;
    assign remainder = neg_rem  ? -rem_q  : rem_q;

endmodule

// File: rtl/multicyc_seq.sv
// multicyc_seq: sequencer for HI/LO multiply, multiply-accumulate and divide.
//   clk, rst  - clock, synchronous active-high reset
//   flush     - squash any in-flight op (wins over a concurrent result handshake)
//   bus       - request/result handshake bundle (slave side)
//   busy      - an op has been accepted and not yet retired; stalls the pipe
// Multiply-class ops return MUL_LATENCY cycles after accept; DIV/DIVU run
// DIV_ITERS iteration cycles plus one sign-fix cycle.
module multicyc_seq
    import cpu_defs::*;
#(
    parameter int MUL_LATENCY = MULTICYC_MUL_LATENCY,
    parameter int DIV_ITERS   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    multicyc_seq_if.slave bus,
    output logic busy
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    mc_state_t  state;
    logic [CNT_W-1:0] cnt;

    oper_t   op_q;
    uint32_t a_q;
    uint32_t b_q;
    uint64_t hilo_q;

    logic    result_valid;
    uint64_t result_hilo;
    uint32_t result_reg;
    logic    hilo_we;
    logic    reg_we;

    logic    req_ready;
    logic    accept;

    logic    div_done;
    uint32_t div_quot;
    uint32_t div_rem;

    uint64_t ext_a;
    uint64_t ext_b;
    uint64_t product;
    uint64_t mul_hilo;

    // rst is folded in so nothing is accepted while reset is held.
    assign req_ready = (state == IDLE) && !flush && !rst;
    assign accept    = bus.req_valid && req_ready;
    assign busy      = (state != IDLE);

    // The divider is started straight from the request so its first
    // iteration lines up with the first DIV_RUN cycle.
    div_iter #(
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && op_is_div(bus.req_op)),
        .is_signed (bus.req_op == DIV),
        .a         (bus.req_a),
        .b         (bus.req_b),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Operands are extended to 64 bits according to signedness; the low 64
    // bits of the product are then identical for signed and unsigned.
    always_comb begin
        ext_a   = op_is_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b   = op_is_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        product = ext_a * ext_b;
        unique case (op_q)
            MADD, MADDU: mul_hilo = hilo_q + product;
            MSUB, MSUBU: mul_hilo = hilo_q - product;
            MUL:         mul_hilo = hilo_q;
            default:     mul_hilo = product;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= bus.req_op;
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            hilo_q <= bus.hilo_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            result_valid <= 1'b0;
            hilo_we      <= 1'b0;
            reg_we       <= 1'b0;
            result_hilo  <= '0;
            result_reg   <= '0;
        end else if (flush) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            hilo_we      <= 1'b0;
            reg_we       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_is_div(bus.req_op)) begin
                            state <= DIV_RUN;
                            cnt   <= CNT_W'(DIV_ITERS - 1);
                        end else begin
                            state <= MUL_WAIT;
                            cnt   <= CNT_W'(MUL_LATENCY - 1);
                        end
                    end
                end
                MUL_WAIT: begin
                    if (cnt == '0) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        result_hilo  <= mul_hilo;
                        result_reg   <= product[31:0];
                        hilo_we      <= (op_q != MUL);
                        reg_we       <= (op_q == MUL);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV_RUN: begin
                    if (cnt == '0) begin
                        state <= DIV_FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV_FIX: begin
                    // Sign-corrected quotient/remainder are captured here.
                    if (div_done) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        result_hilo  <= {div_rem, div_quot};
                        result_reg   <= div_quot;
                        hilo_we      <= 1'b1;
                        reg_we       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        hilo_we      <= 1'b0;
                        reg_we       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.result_valid = result_valid;
    assign bus.result_hilo  = result_hilo;
    assign bus.result_reg   = result_reg;
    assign bus.hilo_we      = hilo_we;
    assign bus.reg_we       = reg_we;

endmodule

// File: tb/tb_multicyc_seq.sv
module tb_multicyc_seq;
    import cpu_defs::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    multicyc_seq_if ifc ();

    multicyc_seq #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_ITERS   (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (ifc),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        uint64_t hilo;
        uint32_t rreg;
        logic    hwe;
        logic    rwe;
        int      lat;
    } exp_t;

    typedef struct {
        oper_t   op;
        uint32_t a;
        uint32_t b;
        uint64_t hilo;
        uint64_t e_hilo;
        uint32_t e_reg;
        logic    e_hwe;
        logic    e_rwe;
        int      e_lat;
        int      hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(oper_t op, uint32_t a, uint32_t b, uint64_t hilo);
        exp_t    e;
        longint  sa = longint'($signed(a));
        longint  sb = longint'($signed(b));
        uint64_t sp = 64'(sa * sb);
        uint64_t up = {32'b0, a} * {32'b0, b};
        longint  q;
        longint  r;
        e.hwe  = 1'b1;
        e.rwe  = 1'b0;
        e.rreg = '0;
        e.lat  = MUL_LAT;
        e.hilo = '0;
        case (op)
            MULT:  e.hilo = sp;
            MULTU: e.hilo = up;
            MADD:  e.hilo = hilo + sp;
            MADDU: e.hilo = hilo + up;
            MSUB:  e.hilo = hilo - sp;
            MSUBU: e.hilo = hilo - up;
            MUL: begin
                e.hilo = hilo;
                e.rreg = sp[31:0];
                e.hwe  = 1'b0;
                e.rwe  = 1'b1;
            end
            DIV: begin
                e.lat = DIV_LAT;
                if (b == 0) begin
                    q = a[31] ? 64'd1 : 64'hFFFF_FFFF;
                    r = sa;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
                e.hilo = {r[31:0], q[31:0]};
            end
            DIVU: begin
                e.lat = DIV_LAT;
                if (b == 0) e.hilo = {a, 32'hFFFF_FFFF};
                else        e.hilo = {a % b, a / b};
            end
            default: e.hilo = '0;
        endcase
        return e;
    endfunction

    task automatic run_op(input string tag, input oper_t op, input uint32_t a, input uint32_t b,
                          input uint64_t hilo, input uint64_t e_hilo, input uint32_t e_reg,
                          input logic e_hwe, input logic e_rwe, input int e_lat, input int hold);
        int      waited;
        int      lat;
        int      bad;
        uint64_t snap_hilo;
        uint32_t snap_reg;
        waited = 0;
        @(negedge clk);
        while (!ifc.req_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " req_ready"}, 64'(ifc.req_ready), 64'd1);
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_a     = a;
        ifc.req_b     = b;
        ifc.hilo_in   = hilo;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        ifc.req_a     = $urandom;
        ifc.req_b     = $urandom;
        ifc.hilo_in   = {$urandom, $urandom};
        lat = 0;
        bad = 0;
        while (!ifc.result_valid && lat < 200) begin
            if (!busy || ifc.hilo_we || ifc.reg_we) bad++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " busy/we while pending"}, 64'(bad), 64'd0);
        check({tag, " result_hilo"}, ifc.result_hilo, e_hilo);
        check({tag, " hilo_we/reg_we"}, {62'b0, ifc.hilo_we, ifc.reg_we}, {62'b0, e_hwe, e_rwe});
        if (e_rwe) check({tag, " result_reg"}, 64'(ifc.result_reg), 64'(e_reg));
        snap_hilo = ifc.result_hilo;
        snap_reg  = ifc.result_reg;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!ifc.result_valid || !busy || ifc.result_hilo !== snap_hilo ||
                ifc.result_reg !== snap_reg || ifc.hilo_we !== e_hwe || ifc.reg_we !== e_rwe) bad++;
        end
        if (hold > 0) check({tag, " stable while stalled"}, 64'(bad), 64'd0);
        ifc.result_ready = 1'b1;
        @(negedge clk);
        ifc.result_ready = 1'b0;
        check({tag, " retire {valid,busy,hwe,rwe}"},
              {60'b0, ifc.result_valid, busy, ifc.hilo_we, ifc.reg_we}, 64'd0);
        check({tag, " ready after retire"}, 64'(ifc.req_ready), 64'd1);
    endtask

    task automatic run_model(input string tag, input oper_t op, input uint32_t a, input uint32_t b,
                             input uint64_t hilo, input int hold);
        exp_t e;
        e = model(op, a, b, hilo);
        run_op(tag, op, a, b, hilo, e.hilo, e.rreg, e.hwe, e.rwe, e.lat, hold);
    endtask

    function automatic uint32_t pick_operand();
        uint32_t v;
        case ($urandom_range(0, 9))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        int      bad;
        int      lat;
        oper_t   rop;
        vecs[0]  = '{MULT,  32'hFFFF_FFFF, 32'd2,          64'd0,                   64'hFFFF_FFFF_FFFF_FFFE, 32'd0,          1'b1, 1'b0, MUL_LAT, 0};
        vecs[1]  = '{MULTU, 32'hFFFF_FFFF, 32'd2,          64'd0,                   64'h0000_0001_FFFF_FFFE, 32'd0,          1'b1, 1'b0, MUL_LAT, 0};
        vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'd2,          64'd0,                   64'hFFFF_FFFF_FFFF_FFFD, 32'd0,          1'b1, 1'b0, DIV_LAT, 5};
        vecs[3]  = '{DIVU,  32'd5,         32'd0,          64'd0,                   64'h0000_0005_FFFF_FFFF, 32'd0,          1'b1, 1'b0, DIV_LAT, 0};
        vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF,  64'd0,                   64'h0000_0000_8000_0000, 32'd0,          1'b1, 1'b0, DIV_LAT, 0};
        vecs[5]  = '{MADDU, 32'd1,         32'd1,          64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   32'd0,          1'b1, 1'b0, MUL_LAT, 0};
        vecs[6]  = '{MUL,   32'd3,         32'hFFFF_FFFC,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 32'hFFFF_FFF4,  1'b0, 1'b1, MUL_LAT, 5};
        vecs[7]  = '{DIV,   32'hFFFF_FFFB, 32'd0,          64'd0,                   64'hFFFF_FFFB_0000_0001, 32'd0,          1'b1, 1'b0, DIV_LAT, 0};
        vecs[8]  = '{DIV,   32'd7,         32'd0,          64'd0,                   64'h0000_0007_FFFF_FFFF, 32'd0,          1'b1, 1'b0, DIV_LAT, 0};
        vecs[9]  = '{MSUB,  32'd2,         32'd3,          64'd10,                  64'd4,                   32'd0,          1'b1, 1'b0, MUL_LAT, 0};
        vecs[10] = '{MADD,  32'hFFFF_FFFF, 32'd1,          64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 32'd0,          1'b1, 1'b0, MUL_LAT, 0};
        vecs[11] = '{MSUBU, 32'd1,         32'd1,          64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 32'd0,          1'b1, 1'b0, MUL_LAT, 0};
        vecs[12] = '{DIVU,  32'hFFFF_FFFF, 32'd10,         64'd0,                   64'h0000_0005_1999_9999, 32'd0,          1'b1, 1'b0, DIV_LAT, 0};
        vecs[13] = '{DIV,   32'd7,         32'hFFFF_FFFE,  64'd0,                   64'h0000_0001_FFFF_FFFD, 32'd0,          1'b1, 1'b0, DIV_LAT, 2};

        rst              = 1'b1;
        flush            = 1'b0;
        ifc.req_valid    = 1'b0;
        ifc.req_op       = MULT;
        ifc.req_a        = '0;
        ifc.req_b        = '0;
        ifc.hilo_in      = '0;
        ifc.result_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset {busy,valid,hwe,rwe,ready}",
              {59'b0, busy, ifc.result_valid, ifc.hilo_we, ifc.reg_we, ifc.req_ready}, 64'd0);
        check("reset result_hilo", ifc.result_hilo, 64'd0);
        check("reset result_reg", 64'(ifc.result_reg), 64'd0);
        rst = 1'b0;
        #1;
        check("ready after reset", 64'(ifc.req_ready), 64'd1);

        // Directed vectors.
        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo,
                   vecs[i].e_hilo, vecs[i].e_reg, vecs[i].e_hwe, vecs[i].e_rwe, vecs[i].e_lat, vecs[i].hold);
        end

        // flush together with req_valid in IDLE: nothing accepted.
        @(negedge clk);
        flush         = 1'b1;
        ifc.req_valid = 1'b1;
        ifc.req_op    = MULT;
        ifc.req_a     = 32'd3;
        ifc.req_b     = 32'd4;
        #1;
        check("flush blocks req_ready", 64'(ifc.req_ready), 64'd0);
        @(negedge clk);
        check("flush+req_valid not accepted", 64'(busy), 64'd0);
        flush         = 1'b0;
        ifc.req_valid = 1'b0;

        // flush during DIV_RUN cycle 10.
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_op    = DIV;
        ifc.req_a     = 32'd100;
        ifc.req_b     = 32'd7;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy before div flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("div flush -> idle {busy,valid}", {62'b0, busy, ifc.result_valid}, 64'd0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifc.result_valid || busy) bad++;
        end
        check("no result after div flush", 64'(bad), 64'd0);
        run_model("post-flush", DIVU, 32'd100, 32'd7, 64'd0, 0);

        // flush concurrent with result_ready in DONE discards the result.
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_op    = MULTU;
        ifc.req_a     = 32'd9;
        ifc.req_b     = 32'd9;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        lat = 0;
        while (!ifc.result_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("flush-in-done latency", 64'(lat), 64'(MUL_LAT));
        flush            = 1'b1;
        ifc.result_ready = 1'b1;
        @(negedge clk);
        flush            = 1'b0;
        ifc.result_ready = 1'b0;
        check("flush in DONE {valid,busy,hwe,rwe}",
              {60'b0, ifc.result_valid, busy, ifc.hilo_we, ifc.reg_we}, 64'd0);

        // rst during MUL_WAIT, with a new request held across reset.
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_op    = MULT;
        ifc.req_a     = 32'd3;
        ifc.req_b     = 32'd5;
        @(negedge clk);
        check("busy in MUL_WAIT", 64'(busy), 64'd1);
        rst           = 1'b1;
        ifc.req_op    = MULTU;
        ifc.req_a     = 32'd6;
        ifc.req_b     = 32'd7;
        ifc.hilo_in   = 64'd0;
        @(negedge clk);
        check("rst mid-op {busy,valid,hwe,rwe,ready}",
              {59'b0, busy, ifc.result_valid, ifc.hilo_we, ifc.reg_we, ifc.req_ready}, 64'd0);
        check("rst mid-op result_hilo", ifc.result_hilo, 64'd0);
        check("rst mid-op result_reg", 64'(ifc.result_reg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready as rst falls", 64'(ifc.req_ready), 64'd1);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        check("held req accepted after rst", 64'(busy), 64'd1);
        lat = 0;
        while (!ifc.result_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("post-rst latency", 64'(lat), 64'(MUL_LAT));
        check("post-rst result_hilo", ifc.result_hilo, 64'd42);
        ifc.result_ready = 1'b1;
        @(negedge clk);
        ifc.result_ready = 1'b0;
        check("post-rst retire", {62'b0, ifc.result_valid, busy}, 64'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            rop = oper_t'(4'($urandom_range(0, 8)));
            run_model($sformatf("rand%0d", i), rop, pick_operand(), pick_operand(),
                      {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
